// File: rtl/hamming_encoder_stream.sv
// rtl/hamming_encoder_stream.sv - streaming Hamming(7,4) encoder with 2-entry skid buffer
// and one-shot single-bit error injection.
module hamming_encoder_stream #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       out_code,
  input  logic             inj_arm,
  input  logic [2:0]       inj_pos,
  output logic             inj_pending,
  output logic [CNT_W-1:0] word_count
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t     state;
  state_t     state_nx;
  logic [6:0] head;
  logic [6:0] skid;
  logic [6:0] enc_code;
  logic [6:0] inj_mask;
  logic [6:0] new_code;
  logic [2:0] inj_pos_q;
  logic       accept;
  logic       xfer;

  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;
  assign out_valid = (state != EMPTY);
  assign out_code  = head;

  // Bit layout shared with the decoder: parity at c1, c2, c3; data at c0, c4, c5, c6.
  always_comb begin
    enc_code    = '0;
    enc_code[0] = in_data[0];
    enc_code[1] = in_data[0] ^ in_data[1] ^ in_data[2];
    enc_code[2] = in_data[0] ^ in_data[1] ^ in_data[3];
    enc_code[3] = in_data[1] ^ in_data[2] ^ in_data[3];
    enc_code[4] = in_data[1];
    enc_code[5] = in_data[2];
    enc_code[6] = in_data[3];
  end

  always_comb begin
    inj_mask = '0;
    if (inj_pending && (inj_pos_q != 3'd0)) begin
      inj_mask = 7'b0000001 << (inj_pos_q - 3'd1);
    end
    new_code = enc_code ^ inj_mask;
  end

  always_comb begin
    state_nx = state;
    case (state)
      EMPTY:   if (accept) state_nx = ONE;
      ONE: begin
        if (accept && !xfer)      state_nx = TWO;
        else if (!accept && xfer) state_nx = EMPTY;
      end
      TWO:     if (xfer) state_nx = ONE;
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= EMPTY;
      in_ready    <= 1'b0;
      head        <= '0;
      skid        <= '0;
      inj_pending <= 1'b0;
      inj_pos_q   <= '0;
      word_count  <= '0;
    end else begin
      state    <= state_nx;
      in_ready <= (state_nx != TWO);

      case (state)
        EMPTY: if (accept) head <= new_code;
        ONE: begin
          if (accept && xfer) head <= new_code;
          else if (accept)    skid <= new_code;
        end
        TWO:     if (xfer) head <= skid;
        default: ;
      endcase

      if (accept) begin
        word_count <= word_count + CNT_W'(1);
      end

      // A coincident arm lands after the accepted word consumed the old armed state.
      if (accept && inj_pending) begin
        inj_pending <= 1'b0;
      end
      if (inj_arm) begin
        inj_pending <= (inj_pos != 3'd0);
        inj_pos_q   <= inj_pos;
      end
    end
  end

endmodule

// File: tb/tb_hamming_encoder_stream.sv
// tb/tb_hamming_encoder_stream.sv - table-driven bench for hamming_encoder_stream.
module tb_hamming_encoder_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_code;
  logic        inj_arm;
  logic [2:0]  inj_pos;
  logic        inj_pending;
  logic [15:0] word_count;

  logic        in_ready4;
  logic        out_valid4;
  logic [6:0]  out_code4;
  logic        inj_pending4;
  logic [3:0]  word_count4;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  hamming_encoder_stream dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
    .inj_arm(inj_arm), .inj_pos(inj_pos), .inj_pending(inj_pending), .word_count(word_count)
  );

  hamming_encoder_stream #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready), .out_code(out_code4),
    .inj_arm(inj_arm), .inj_pos(inj_pos), .inj_pending(inj_pending4), .word_count(word_count4)
  );

  typedef struct {
    logic [3:0] data;
    logic [2:0] pos;
    logic [6:0] code;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
    end else begin
      step();
      in_valid = 1'b0;
      exp_cnt++;
    end
  endtask

  task automatic arm(input logic [2:0] p);
    inj_arm = 1'b1;
    inj_pos = p;
    step();
    inj_arm = 1'b0;
    inj_pos = 3'd0;
  endtask

  // Reference decoder: returns {syndrome, corrected data}.
  function automatic logic [6:0] decode(input logic [6:0] c);
    logic [2:0] s;
    logic [6:0] f;
    s[0] = c[0] ^ c[2] ^ c[4] ^ c[6];
    s[1] = c[1] ^ c[2] ^ c[5] ^ c[6];
    s[2] = c[3] ^ c[4] ^ c[5] ^ c[6];
    f = c;
    if (s != 3'd0) f[s - 3'd1] = ~f[s - 3'd1];
    return {s, f[6], f[5], f[4], f[0]};
  endfunction

  initial begin
    vecs[0]  = '{4'h0, 3'd0, 7'b0000000};
    vecs[1]  = '{4'h1, 3'd0, 7'b0000111};
    vecs[2]  = '{4'h2, 3'd0, 7'b0011110};
    vecs[3]  = '{4'h3, 3'd0, 7'b0011001};
    vecs[4]  = '{4'h4, 3'd0, 7'b0101010};
    vecs[5]  = '{4'h5, 3'd0, 7'b0101101};
    vecs[6]  = '{4'h6, 3'd0, 7'b0110100};
    vecs[7]  = '{4'h7, 3'd0, 7'b0110011};
    vecs[8]  = '{4'h8, 3'd0, 7'b1001100};
    vecs[9]  = '{4'h9, 3'd0, 7'b1001011};
    vecs[10] = '{4'hA, 3'd0, 7'b1010010};
    vecs[11] = '{4'hB, 3'd0, 7'b1010101};
    vecs[12] = '{4'hC, 3'd0, 7'b1100110};
    vecs[13] = '{4'hD, 3'd0, 7'b1100001};
    vecs[14] = '{4'hE, 3'd0, 7'b1111000};
    vecs[15] = '{4'hF, 3'd0, 7'b1111111};
    vecs[16] = '{4'hB, 3'd3, 7'b1010001};
    vecs[17] = '{4'h0, 3'd1, 7'b0000001};
    vecs[18] = '{4'hF, 3'd7, 7'b0111111};
    vecs[19] = '{4'h6, 3'd4, 7'b0111100};

    rst = 1'b1; in_valid = 1'b0; in_data = 4'h0; out_ready = 1'b1;
    inj_arm = 1'b0; inj_pos = 3'd0;
    step(); step();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_code", 32'(out_code), 32'd0);
    chk("rst_inj_pending", 32'(inj_pending), 32'd0);
    chk("rst_word_count", 32'(word_count), 32'd0);
    rst = 1'b0;
    step();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_out_valid", 32'(out_valid), 32'd0);

    send(4'b1011);
    chk("first_valid", 32'(out_valid), 32'd1);
    chk("first_code", 32'(out_code), 32'b1010101);
    chk("first_count", 32'(word_count), 32'd1);
    step();
    chk("first_drained", 32'(out_valid), 32'd0);

    // Back-to-back at full throughput.
    in_valid = 1'b1;
    in_data = 4'h0; step(); exp_cnt++;
    chk("b2b0_code", 32'(out_code), 32'b0000000);
    chk("b2b0_ready", 32'(in_ready), 32'd1);
    in_data = 4'h1; step(); exp_cnt++;
    chk("b2b1_code", 32'(out_code), 32'b0000111);
    chk("b2b1_ready", 32'(in_ready), 32'd1);
    in_data = 4'hF; step(); exp_cnt++;
    chk("b2b2_code", 32'(out_code), 32'b1111111);
    chk("b2b2_ready", 32'(in_ready), 32'd1);
    chk("b2b2_valid", 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    step();
    chk("b2b_count", 32'(word_count), 32'(exp_cnt));

    for (int i = 0; i < 20; i++) begin
      if (vecs[i].pos != 3'd0) begin
        arm(vecs[i].pos);
        chk($sformatf("tbl%0d_armed", i), 32'(inj_pending), 32'd1);
      end
      send(vecs[i].data);
      chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("tbl%0d_code", i), 32'(out_code), 32'(vecs[i].code));
      chk($sformatf("tbl%0d_pending", i), 32'(inj_pending), 32'd0);
    end
    step();

    // Stall: two words fill the buffer, the third is held off.
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 4'h1; step(); exp_cnt++;
    chk("stall_ready1", 32'(in_ready), 32'd1);
    in_data = 4'h2; step(); exp_cnt++;
    chk("stall_ready2", 32'(in_ready), 32'd0);
    in_data = 4'h3;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("stall_hold%0d", k), 32'(out_code), 32'b0000111);
      chk($sformatf("stall_valid%0d", k), 32'(out_valid), 32'd1);
    end
    chk("stall_count", 32'(word_count), 32'(exp_cnt));
    out_ready = 1'b1;
    step();
    chk("stall_out2", 32'(out_code), 32'b0011110);
    chk("stall_reopen", 32'(in_ready), 32'd1);
    step(); exp_cnt++;
    in_valid = 1'b0;
    chk("stall_out3", 32'(out_code), 32'b0011001);
    chk("stall_out3_valid", 32'(out_valid), 32'd1);
    step();
    chk("stall_empty", 32'(out_valid), 32'd0);
    chk("stall_count2", 32'(word_count), 32'(exp_cnt));

    // Injection: plain arm then clean follow-up word.
    arm(3'd3);
    send(4'b1011);
    chk("inj_code", 32'(out_code), 32'b1010001);
    chk("inj_cleared", 32'(inj_pending), 32'd0);
    send(4'b1011);
    chk("inj_next_clean", 32'(out_code), 32'b1010101);

    // Arm coincident with accept: current word clean, next word hit.
    inj_arm = 1'b1; inj_pos = 3'd1;
    send(4'h0);
    inj_arm = 1'b0; inj_pos = 3'd0;
    chk("coinc_code", 32'(out_code), 32'b0000000);
    chk("coinc_pending", 32'(inj_pending), 32'd1);
    send(4'h0);
    chk("coinc_next", 32'(out_code), 32'b0000001);

    arm(3'd5); arm(3'd2);
    send(4'h0);
    chk("rearm_code", 32'(out_code), 32'b0000010);
    arm(3'd4); arm(3'd0);
    chk("disarm_pending", 32'(inj_pending), 32'd0);
    send(4'h0);
    chk("disarm_code", 32'(out_code), 32'b0000000);
    step();

    // Exhaustive encode plus every single-bit injection through the reference decoder.
    for (int d = 0; d < 16; d++) begin
      logic [6:0] r;
      send(4'(d));
      r = decode(out_code);
      chk($sformatf("dec%0d_syn", d), 32'(r[6:4]), 32'd0);
      chk($sformatf("dec%0d_data", d), 32'(r[3:0]), 32'(d));
      for (int p = 1; p < 8; p++) begin
        arm(3'(p));
        send(4'(d));
        r = decode(out_code);
        chk($sformatf("dec%0d_p%0d_syn", d, p), 32'(r[6:4]), 32'(p));
        chk($sformatf("dec%0d_p%0d_data", d, p), 32'(r[3:0]), 32'(d));
      end
    end
    step();
    chk("count_total", 32'(word_count), 32'(exp_cnt));
    chk("count4_total", 32'(word_count4), 32'(exp_cnt % 16));

    // Reset with buffer full and injection pending.
    out_ready = 1'b0;
    send(4'h5); send(4'h6);
    arm(3'd2);
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    chk("pre_rst_pending", 32'(inj_pending), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 0;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_pending", 32'(inj_pending), 32'd0);
    chk("mid_rst_count", 32'(word_count), 32'd0);
    step();
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_valid2", 32'(out_valid), 32'd0);

    // Counter wrap on the 4-bit instance.
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) send(4'(i));
    chk("wrap_count4", 32'(word_count4), 32'd1);
    chk("wrap_count16", 32'(word_count), 32'd17);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
